fft_delay_line: RTL

Parametrised multi-lane delay line for the FFT feedback/commutator path, successor to the fixed 16-lane shift memory. It stores blocks of LANES complex samples, with a runtime-selectable depth in blocks. It adds valid/ready handshaking, fill tracking, output-valid generation and a flush/drain mode. It sits between butterfly stages, and the stage controller sets its depth per FFT size.

---
 rtl/fft_dl_pkg.sv | 28 ++
 rtl/fft_dl_ctrl.sv | 115 +++++++++++
 rtl/fft_delay_line.sv | 88 ++++++++
 3 files changed

// File: rtl/fft_dl_pkg.sv
// Shared types and helpers for the FFT multi-lane delay line.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fft_dl_pkg;

  // Default sample width for the complex sample container.
  localparam int DEF_WIDTH = 9;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FILL,
    ST_FULL,
    ST_DRAIN
  } state_t;

  typedef struct packed {
    logic signed [DEF_WIDTH-1:0] re;
    logic signed [DEF_WIDTH-1:0] im;
  } cplx_t;

  // A zero depth means "one block"; anything beyond the storage is capped.
  function automatic int clamp_depth(input int d, input int maxd);
    if (d < 1) return 1;
    if (d > maxd) return maxd;
    return d;
  endfunction

endpackage

// File: rtl/fft_dl_ctrl.sv
// Delay-line controller: FSM, fill counter, depth latch, handshake outputs.
// Latency: handshake outputs are combinational from state and inputs; state updates next clk.
// Backpressure: FULL ties in_ready to out_ready; DRAIN ignores input and waits on out_ready.
// Ports: clk/rstn; cfg_depth latched on the first accepted beat in EMPTY; in_valid/out_ready/flush
// requests; in_ready/out_valid handshake; fill, depth_q, busy status; shift/zero_in storage controls.
module fft_dl_ctrl
  import fft_dl_pkg::*;
#(
  parameter int MAX_DEPTH = 16,
  parameter int DW        = $clog2(MAX_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [DW-1:0] cfg_depth,
  input  logic          in_valid,
  input  logic          out_ready,
  input  logic          flush,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] fill,
  output logic [DW-1:0] depth_q,
  output logic          shift,
  output logic          zero_in,
  output logic          busy
);

  state_t        state_q, state_d;
  logic [DW-1:0] fill_q, fill_d;
  logic [DW-1:0] depth_r, depth_d;
  logic [DW-1:0] pad_q, pad_d;
  logic [DW-1:0] fill_inc;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_EMPTY;
      fill_q  <= '0;
      depth_r <= DW'(MAX_DEPTH);
      pad_q   <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      depth_r <= depth_d;
      pad_q   <= pad_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    depth_d   = depth_r;
    pad_d     = pad_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    shift     = 1'b0;
    zero_in   = 1'b0;
    fill_inc  = fill_q;
    case (state_q)
      ST_EMPTY: begin
        in_ready = 1'b1;
        if (in_valid) begin
          shift   = 1'b1;
          depth_d = DW'(clamp_depth(int'(cfg_depth), MAX_DEPTH));
          fill_d  = DW'(1);
          state_d = (depth_d == DW'(1)) ? ST_FULL : ST_FILL;
        end
      end
      ST_FILL: begin
        in_ready = 1'b1;
        shift    = in_valid;
        fill_inc = fill_q + DW'(in_valid);
        fill_d   = fill_inc;
        if (flush) begin
          // Blocks younger than depth_r need this many zero shifts
          // before the oldest one reaches the read tap.
          state_d = ST_DRAIN;
          pad_d   = depth_r - fill_inc;
        end else if (fill_inc == depth_r) begin
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        out_valid = in_valid;
        in_ready  = out_ready;
        shift     = in_valid && out_ready;
        if (flush) begin
          state_d = ST_DRAIN;
          pad_d   = '0;
        end
      end
      ST_DRAIN: begin
        zero_in = 1'b1;
        if (pad_q != '0) begin
          // Alignment shifts: the tap holds padding, so nothing is offered.
          if (out_ready) begin
            shift = 1'b1;
            pad_d = pad_q - DW'(1);
          end
        end else begin
          out_valid = 1'b1;
          if (out_ready) begin
            shift  = 1'b1;
            fill_d = fill_q - DW'(1);
            if (fill_q == DW'(1)) state_d = ST_EMPTY;
          end
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  assign fill    = fill_q;
  assign depth_q = depth_r;
  assign busy    = (state_q != ST_EMPTY);

endmodule

// File: rtl/fft_delay_line.sv
// Multi-lane block delay line for the FFT commutator path; optional blk_cnt port with FFT_DL_CNT_EN.
// Latency: dout is the block accepted exactly depth_q accepted beats earlier (combinational tap).
// Backpressure: valid/ready both sides; any stall freezes storage and state.
// Ports: clk, rstn (sync active-low); cfg_depth; in_valid/in_ready with din_re/din_im;
// flush; out_valid/out_ready with dout_re/dout_im; fill (blocks held); busy; blk_cnt (optional).
module fft_delay_line
  import fft_dl_pkg::*;
#(
  parameter int WIDTH     = 9,
  parameter int LANES     = 16,
  parameter int MAX_DEPTH = 16,
  localparam int DW       = $clog2(MAX_DEPTH + 1)
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic [DW-1:0]                       cfg_depth,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic signed [LANES-1:0][WIDTH-1:0]  din_re,
  input  logic signed [LANES-1:0][WIDTH-1:0]  din_im,
  input  logic                                flush,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic signed [LANES-1:0][WIDTH-1:0]  dout_re,
  output logic signed [LANES-1:0][WIDTH-1:0]  dout_im,
  output logic [DW-1:0]                       fill,
`ifdef FFT_DL_CNT_EN
  output logic [15:0]                         blk_cnt,
`endif
  output logic                                busy
);

  localparam int AW = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;

  logic [MAX_DEPTH-1:0][LANES-1:0][WIDTH-1:0] mem_re;
  logic [MAX_DEPTH-1:0][LANES-1:0][WIDTH-1:0] mem_im;
  logic [DW-1:0] depth_q;
  logic [AW-1:0] rd_idx;
  logic          shift;
  logic          zero_in;

  fft_dl_ctrl #(
    .MAX_DEPTH (MAX_DEPTH),
    .DW        (DW)
  ) u_ctrl (
    .clk       (clk),
    .rstn      (rstn),
    .cfg_depth (cfg_depth),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .flush     (flush),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .fill      (fill),
    .depth_q   (depth_q),
    .shift     (shift),
    .zero_in   (zero_in),
    .busy      (busy)
  );

  // Block shift register: entry 0 is the newest block.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      mem_re <= '0;
      mem_im <= '0;
    end else if (shift) begin
      for (int i = MAX_DEPTH - 1; i > 0; i--) begin
        mem_re[i] <= mem_re[i-1];
        mem_im[i] <= mem_im[i-1];
      end
      mem_re[0] <= zero_in ? '0 : din_re;
      mem_im[0] <= zero_in ? '0 : din_im;
    end
  end

  // Tap at the block that the next shift will displace.
  assign rd_idx  = AW'(depth_q - DW'(1));
  assign dout_re = mem_re[rd_idx];
  assign dout_im = mem_im[rd_idx];

`ifdef FFT_DL_CNT_EN
  always_ff @(posedge clk) begin
    if (!rstn) blk_cnt <= '0;
    else if (out_valid && out_ready) blk_cnt <= blk_cnt + 16'd1;
  end
`endif

endmodule
